slow_clk_monitor: RTL and testbench

//  Receive-side checker for a divided clock produced elsewhere in the design (e.g. CLK/8 or CLK/2^19).

---
 rtl/clk_mon_pkg.sv | 20 ++
 rtl/clk_mon_sync.sv | 52 +++++
 rtl/slow_clk_monitor.sv | 124 ++++++++++++
 tb/tb_slow_clk_monitor.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_mon_pkg.sv
// Shared types and default constants for the slow clock monitor.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MEAS   = 2'd1,
    ST_LOCKED = 2'd2
  } mon_state_t;

  localparam int DEF_CNT_W      = 21;
  localparam int DEF_EXP_PERIOD = 524288;
  localparam int DEF_TOL        = 64;
  localparam int DEF_LOCK_N     = 4;

  // Lower tolerance bound, clamped at zero.
  function automatic int tol_lo(input int exp_period, input int tol);
    return (exp_period > tol) ? exp_period - tol : 0;
  endfunction

endpackage

// File: rtl/clk_mon_sync.sv
// Brings SLOW_IN into the CLK domain and flags its rising edges.
// Define CLK_MON_FILTER_EN to add a 3-sample majority filter that rejects one-cycle glitches.
module clk_mon_sync
  import clk_mon_pkg::*;
(
  input  logic CLK,
  input  logic RST_N,
  input  logic SLOW_IN,
  output logic rise
);

  logic s1, s2, s3;

`ifdef CLK_MON_FILTER_EN
  logic s4, f, f_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      s3  <= 1'b0;
      s4  <= 1'b0;
      f   <= 1'b0;
      f_d <= 1'b0;
    end else begin
      s1  <= SLOW_IN;
      s2  <= s1;
      s3  <= s2;
      s4  <= s3;
      f   <= (s2 & s3) | (s2 & s4) | (s3 & s4);
      f_d <= f;
    end
  end

  assign rise = f & ~f_d;
`else
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= SLOW_IN;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
`endif

endmodule

// File: rtl/slow_clk_monitor.sv
// Measures the period of a divided clock in CLK cycles and tracks lock against EXP_PERIOD.
// CLK_MON_FILTER_EN (see clk_mon_sync) adds glitch filtering and two cycles of TICK latency.
//
// state     | meaning
// ST_IDLE   | no reference edge yet; waiting for first rise
// ST_MEAS   | measuring periods, counting consecutive good ones
// ST_LOCKED | LOCK_N good periods seen; any bad period or timeout drops lock
module slow_clk_monitor
  import clk_mon_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int EXP_PERIOD = DEF_EXP_PERIOD,
  parameter int TOL        = DEF_TOL,
  parameter int LOCK_N     = DEF_LOCK_N
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             SLOW_IN,
  output logic             TICK,
  output logic [CNT_W-1:0] PERIOD,
  output logic             PERIOD_VLD,
  output logic             LOCKED,
  output logic             ERR
);

  localparam int               GOOD_W    = $clog2(LOCK_N + 1);
  localparam logic [31:0]      LO_BOUND  = 32'(tol_lo(EXP_PERIOD, TOL));
  localparam logic [31:0]      HI_BOUND  = 32'(EXP_PERIOD + TOL);
  localparam logic [31:0]      TO_COUNT  = 32'(2 * EXP_PERIOD);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_N - 1);

  logic              rise;
  logic [CNT_W-1:0]  pcnt;
  logic [31:0]       pcnt_ext;
  logic [GOOD_W-1:0] good;
  logic              in_tol;
  logic              timeout;
  mon_state_t        state;

  clk_mon_sync u_sync (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .SLOW_IN (SLOW_IN),
    .rise    (rise)
  );

  assign pcnt_ext = 32'(pcnt);
  assign in_tol   = (pcnt_ext >= LO_BOUND) && (pcnt_ext <= HI_BOUND);
  // A rise on the timeout cycle is a valid (if long) period, so it wins.
  assign timeout  = (state != ST_IDLE) && (pcnt_ext == TO_COUNT) && !rise;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pcnt <= '0;
    end else if (rise) begin
      pcnt <= CNT_W'(1);
    end else if (pcnt != '1) begin
      pcnt <= pcnt + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_IDLE;
      good       <= '0;
      TICK       <= 1'b0;
      PERIOD     <= '0;
      PERIOD_VLD <= 1'b0;
      LOCKED     <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      TICK       <= rise;
      PERIOD_VLD <= 1'b0;
      ERR        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rise) state <= ST_MEAS;
        end
        ST_MEAS: begin
          if (rise) begin
            PERIOD     <= pcnt;
            PERIOD_VLD <= 1'b1;
            if (in_tol) begin
              good <= good + GOOD_W'(1);
              if (good == GOOD_LAST) begin
                LOCKED <= 1'b1;
                state  <= ST_LOCKED;
              end
            end else begin
              good <= '0;
            end
          end else if (timeout) begin
            ERR   <= 1'b1;
            good  <= '0;
            state <= ST_IDLE;
          end
        end
        ST_LOCKED: begin
          if (rise) begin
            PERIOD     <= pcnt;
            PERIOD_VLD <= 1'b1;
            if (!in_tol) begin
              ERR    <= 1'b1;
              LOCKED <= 1'b0;
              good   <= '0;
              state  <= ST_MEAS;
            end
          end else if (timeout) begin
            ERR    <= 1'b1;
            LOCKED <= 1'b0;
            good   <= '0;
            state  <= ST_IDLE;
          end
        end
        default: begin
          state  <= ST_IDLE;
          good   <= '0;
          LOCKED <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slow_clk_monitor.sv
// Self-checking bench for slow_clk_monitor: directed period table, corner sequences and random periods.
module tb_slow_clk_monitor;

  localparam int CNT_W  = 5;
  localparam int EXP    = 8;
  localparam int TOL    = 1;
  localparam int LOCK_N = 2;
`ifdef CLK_MON_FILTER_EN
  localparam int LAT         = 4;
  localparam bit GLITCH_TICK = 1'b0;
`else
  localparam int LAT         = 2;
  localparam bit GLITCH_TICK = 1'b1;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             slow_in = 1'b0;
  logic             tick;
  logic [CNT_W-1:0] period;
  logic             period_vld;
  logic             locked;
  logic             err;

  int n_checks = 0;
  int n_fail   = 0;

  slow_clk_monitor #(
    .CNT_W(CNT_W), .EXP_PERIOD(EXP), .TOL(TOL), .LOCK_N(LOCK_N)
  ) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .SLOW_IN    (slow_in),
    .TICK       (tick),
    .PERIOD     (period),
    .PERIOD_VLD (period_vld),
    .LOCKED     (locked),
    .ERR        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: SLOW_IN samples per CLK edge, rising-edge times and period arithmetic.
  bit hist[$];
  bit m_armed;
  int m_last;
  int m_good;
  bit m_lock;
  bit m_tick;
  int m_period;
  bit m_vld;
  bit m_err;

  function automatic bit samp(int k);
    return (k < 0 || k >= hist.size()) ? 1'b0 : hist[k];
  endfunction

  function automatic bit filt_level(int k);
    int ones;
    ones = int'(samp(k)) + int'(samp(k - 1)) + int'(samp(k - 2));
    return ones >= 2;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_armed = 0; m_last = 0; m_good = 0; m_lock = 0;
    m_tick = 0; m_period = 0; m_vld = 0; m_err = 0;
  endtask

  task automatic model_step(input bit v);
    int e;
    int p;
    bit r;
    hist.push_back(v);
    e = hist.size() - 1;
`ifdef CLK_MON_FILTER_EN
    r = filt_level(e - 3) && !filt_level(e - 4);
`else
    r = samp(e - 2) && !samp(e - 3);
`endif
    m_tick = r;
    m_vld  = 0;
    m_err  = 0;
    if (r) begin
      if (m_armed) begin
        p = e - m_last;
        m_period = p;
        m_vld = 1;
        if (p >= EXP - TOL && p <= EXP + TOL) begin
          if (!m_lock) begin
            m_good++;
            if (m_good >= LOCK_N) m_lock = 1;
          end
        end else begin
          if (m_lock) m_err = 1;
          m_lock = 0;
          m_good = 0;
        end
      end
      m_armed = 1;
      m_last  = e;
    end else if (m_armed && (e - m_last) == 2 * EXP) begin
      m_err   = 1;
      m_lock  = 0;
      m_good  = 0;
      m_armed = 0;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("model.tick",   32'(tick),       32'(m_tick));
    chk("model.period", 32'(period),     32'(m_period));
    chk("model.vld",    32'(period_vld), 32'(m_vld));
    chk("model.locked", 32'(locked),     32'(m_lock));
    chk("model.err",    32'(err),        32'(m_err));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".tick"},   32'(tick),       0);
    chk({tag, ".period"}, 32'(period),     0);
    chk({tag, ".vld"},    32'(period_vld), 0);
    chk({tag, ".locked"}, 32'(locked),     0);
    chk({tag, ".err"},    32'(err),        0);
  endtask

  // Called just after a negedge; returns just after the following negedge.
  task automatic drive_cycle(input bit v);
    slow_in = v;
    @(posedge clk);
    model_step(v);
    #1;
    cmp_model();
    @(negedge clk);
  endtask

  task automatic run_period(input int hi, input int lo);
    for (int c = 0; c < hi + lo; c++) drive_cycle(c < hi);
  endtask

  typedef struct {
    int hi;
    int lo;
    int exp_period;
    bit exp_vld;
    bit exp_lock;
    bit exp_err;
  } vec_t;

  vec_t vecs[13];

  initial begin
    // Expectations are sampled at the TICK of each record's rising edge.
    vecs[0]  = '{4, 4, 0,  0, 0, 0};
    vecs[1]  = '{4, 4, 8,  1, 0, 0};
    vecs[2]  = '{4, 4, 8,  1, 1, 0};
    vecs[3]  = '{4, 8, 8,  1, 1, 0};
    vecs[4]  = '{4, 4, 12, 1, 0, 1};
    vecs[5]  = '{4, 4, 8,  1, 0, 0};
    vecs[6]  = '{4, 3, 8,  1, 1, 0};
    vecs[7]  = '{5, 5, 7,  1, 1, 0};
    vecs[8]  = '{4, 5, 10, 1, 0, 1};
    vecs[9]  = '{4, 2, 9,  1, 0, 0};
    vecs[10] = '{4, 4, 6,  1, 0, 0};
    vecs[11] = '{4, 4, 8,  1, 0, 0};
    vecs[12] = '{4, 4, 8,  1, 1, 0};

    model_reset();

    // Held in reset with SLOW_IN toggling: all outputs stay 0.
    rst_n = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk_zero("reset");
      slow_in = 1'($urandom_range(0, 1));
    end
    slow_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (3) drive_cycle(0);

    // Period table: lock, stretch/relock, tolerance boundaries.
    for (int i = 0; i < 13; i++) begin
      for (int c = 0; c < vecs[i].hi + vecs[i].lo; c++) begin
        drive_cycle(c < vecs[i].hi);
        if (c == LAT) begin
          chk($sformatf("vec%0d.tick", i),   32'(tick),       1);
          chk($sformatf("vec%0d.period", i), 32'(period),     32'(vecs[i].exp_period));
          chk($sformatf("vec%0d.vld", i),    32'(period_vld), 32'(vecs[i].exp_vld));
          chk($sformatf("vec%0d.locked", i), 32'(locked),     32'(vecs[i].exp_lock));
          chk($sformatf("vec%0d.err", i),    32'(err),        32'(vecs[i].exp_err));
        end
      end
    end

    // Timeout while locked: SLOW_IN stuck low, ERR exactly 16 cycles after the last TICK.
    for (int c = 8; c <= LAT + 17; c++) begin
      drive_cycle(0);
      if (c == LAT + 15) begin
        chk("timeout.early_err", 32'(err),    0);
        chk("timeout.early_lck", 32'(locked), 1);
      end
      if (c == LAT + 16) begin
        chk("timeout.err",    32'(err),    1);
        chk("timeout.locked", 32'(locked), 0);
      end
    end
    for (int c = 0; c < 8; c++) begin
      drive_cycle(c < 4);
      if (c == LAT) begin
        chk("after_to.tick", 32'(tick),       1);
        chk("after_to.vld",  32'(period_vld), 0);
      end
    end
    repeat (3) run_period(4, 4);
    chk("relock.locked", 32'(locked), 1);

    // Async reset between edges while locked.
    run_period(3, 0);
    rst_n = 1'b0;
    slow_in = 1'b0;
    #1;
    chk_zero("async_rst");
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    repeat (2) drive_cycle(0);
    for (int c = 0; c < 8; c++) begin
      drive_cycle(c < 4);
      if (c == LAT) begin
        chk("post_rst.tick", 32'(tick),       1);
        chk("post_rst.vld",  32'(period_vld), 0);
      end
    end

    // Let it time out to idle, then a one-cycle glitch, then a clean edge for latency.
    repeat (24) drive_cycle(0);
    for (int c = 0; c < 10; c++) begin
      drive_cycle(c == 0);
      if (c == 2) chk("glitch.tick", 32'(tick), 32'(GLITCH_TICK));
      if (c == 4) chk("glitch.late", 32'(tick), 0);
    end
    repeat (24) drive_cycle(0);
    for (int c = 0; c < 8; c++) begin
      drive_cycle(c < 4);
      if (c == LAT - 1) chk("latency.early", 32'(tick), 0);
      if (c == LAT)     chk("latency.tick",  32'(tick), 1);
    end

    // Random periods: mostly near nominal, some far off, some long enough to time out.
    for (int i = 0; i < 200; i++) begin
      int sel, per, hi;
      sel = int'($urandom_range(0, 19));
      if (sel < 13)      per = int'($urandom_range(EXP - TOL, EXP + TOL));
      else if (sel < 18) per = int'($urandom_range(3, 14));
      else               per = int'($urandom_range(16, 22));
      hi = int'($urandom_range(1, per - 1));
      run_period(hi, per - hi);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
